// File: rtl/mcs51_timer_array.sv
// mcs51_timer_array: NCH-channel MCS-51 timer/counter on the naive-memory SFR bus.
// Define TIMER_CAPTURE_EN to build mode-11 capture (CAP registers and CF flag).
module mcs51_timer_array #(
   parameter int         NCH       = 2,
   parameter int         WIDTH     = 16,
   parameter int         PRESCALE  = 12,
   parameter logic [7:0] BASE_ADDR = 8'hC0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_sel,
   input  logic             mem_we_n,
   input  logic             mem_rd_n,
   input  logic             mem_sfr_n,
   input  logic [15:0]      mem_addr,
   input  logic [7:0]       mem_wdata,
   output logic [7:0]       mem_rdata,
   output logic             mem_ready_out,
   input  logic [NCH-1:0]   cnt_in,
   input  logic [NCH-1:0]   gate_in,
   output logic [NCH-1:0]   irq
);
   localparam int NB = WIDTH / 8;

   function automatic logic [WIDTH-1:0] put(input logic [WIDTH-1:0] v, input logic [1:0] b, input logic [7:0] d);
      logic [31:0] t;
      t = 32'(v);
      t[{b, 3'b000} +: 8] = d;
      return t[WIDTH-1:0];
   endfunction

   logic [7:0] pre_q, off, rsel, c8;
   logic tick, acc, hit, wr, rd, rd_acc, unused_hi;
   logic [1:0] chn, ss;
   logic [3:0] rg;
   logic [4:0] bo;
   logic [5:0] cs;
   logic [31:0] s32, r32, p32;
   logic [NCH-1:0] cs1_q, cs2_q, ch_q, gs1_q, gs2_q, cfall;
   logic [NCH-1:0][5:0] ctrl_v;
   logic [NCH-1:0][1:0] stat_v;
   logic [NCH-1:0][7:0] lo_v;
   logic [NCH-1:0][WIDTH-1:0] rl_v, cap_v, sh_v;

   assign tick = pre_q == 8'(PRESCALE - 1);
   assign cfall = ch_q & ~cs2_q;
   assign acc = mem_sel & ~mem_sfr_n;
   assign off = mem_addr[7:0] - BASE_ADDR;
   assign hit = acc & (off < 8'(16 * NCH));
   assign wr = hit & ~mem_we_n;
   assign rd = hit & ~mem_rd_n;
   assign rd_acc = acc & ~mem_rd_n;
   assign chn = off[5:4];
   assign rg = off[3:0];
   assign bo = {rg[1:0], 3'b000};
   assign unused_hi = ^mem_addr[15:8];

   always_ff @(posedge clk) begin
      pre_q <= (reset | tick) ? 8'd0 : pre_q + 8'd1;
      {ch_q, cs2_q, cs1_q} <= reset ? '0 : {cs2_q, cs1_q, cnt_in};
      {gs2_q, gs1_q} <= reset ? '0 : {gs1_q, gate_in};
   end

`ifdef TIMER_CAPTURE_EN
   logic [NCH-1:0] gh_q, gfall;
   assign gfall = gh_q & ~gs2_q;
   always_ff @(posedge clk)
      gh_q <= reset ? '0 : gs2_q;
`endif

   for (genvar g = 0; g < NCH; g++) begin : ch
      logic [5:0] ctrl_q, ctrl_d;
      logic tf_q, tf_d, cf_q, sel, ctrl_wr, stat_wr, cnt_wr, rl_wr, cap_md, en, evt, ovf;
      logic [WIDTH-1:0] cnt_q, cnt_d, rl_q, rl_d, sh_q, cap_q;
      assign sel = chn == 2'(g);
      assign ctrl_wr = wr & sel & (rg == 4'd0);
      assign stat_wr = wr & sel & (rg == 4'd1);
      assign cnt_wr = wr & sel & (rg[3:2] == 2'b01) & (32'(rg[1:0]) < NB);
      assign rl_wr = wr & sel & (rg[3:2] == 2'b10) & (32'(rg[1:0]) < NB);
      assign en = ctrl_q[0] & (cap_md | ~ctrl_q[4] | gs2_q[g]);
      // A CPU write to CNT owns the register this cycle, so the event is dropped
      assign evt = en & (ctrl_q[3] ? cfall[g] : tick) & ~cnt_wr;
      assign ovf = evt & (&cnt_q);
      always_comb begin
         cnt_d = cnt_wr ? put(cnt_q, rg[1:0], mem_wdata) : ovf ? (ctrl_q[2:1] == 2'b01 ? rl_q : '0) : evt ? cnt_q + 1'b1 : cnt_q;
         ctrl_d = ctrl_wr ? mem_wdata[5:0] : (ovf & ctrl_q[2:1] == 2'b10) ? {ctrl_q[5:1], 1'b0} : ctrl_q;
         tf_d = (tf_q & ~(stat_wr & mem_wdata[0])) | ovf;
         rl_d = rl_wr ? put(rl_q, rg[1:0], mem_wdata) : rl_q;
      end
      always_ff @(posedge clk)
         if (reset) begin
            ctrl_q <= '0;
            tf_q <= 1'b0;
            cnt_q <= '0;
            rl_q <= '0;
            sh_q <= '0;
         end else begin
            ctrl_q <= ctrl_d;
            tf_q <= tf_d;
            cnt_q <= cnt_d;
            rl_q <= rl_d;
            if (rd & sel & (rg == 4'd4)) sh_q <= cnt_q;
         end
`ifdef TIMER_CAPTURE_EN
      logic capt;
      assign cap_md = ctrl_q[2:1] == 2'b11;
      assign capt = gfall[g] & ctrl_q[0] & cap_md;
      always_ff @(posedge clk) begin
         cap_q <= reset ? '0 : capt ? cnt_q : cap_q;
         cf_q <= reset ? 1'b0 : (cf_q & ~(stat_wr & mem_wdata[1])) | capt;
      end
`else
      assign cap_md = 1'b0;
      assign cap_q = '0;
      assign cf_q = 1'b0;
`endif
      assign irq[g] = ctrl_q[5] & (tf_q | cf_q);
      assign ctrl_v[g] = ctrl_q;
      assign stat_v[g] = {cf_q, tf_q};
      assign lo_v[g] = cnt_q[7:0];
      assign rl_v[g] = rl_q;
      assign cap_v[g] = cap_q;
      assign sh_v[g] = sh_q;
   end

   always_comb begin
      cs = '0;
      ss = '0;
      c8 = '0;
      s32 = '0;
      r32 = '0;
      p32 = '0;
      for (int i = 0; i < NCH; i++)
         if (chn == 2'(i)) begin
            cs = ctrl_v[i];
            ss = stat_v[i];
            c8 = lo_v[i];
            s32 = 32'(sh_v[i]);
            r32 = 32'(rl_v[i]);
            p32 = 32'(cap_v[i]);
         end
   end

   // Byte 0 of CNT reads live (and snapshots); bytes 1..3 come from the snapshot
   assign rsel = !hit ? 8'h00 :
                 rg[3:2] == 2'b00 ? (rg[1:0] == 2'b00 ? {2'b00, cs} : rg[1:0] == 2'b01 ? {6'b0, ss} : 8'h00) :
                 rg[3:2] == 2'b01 ? (rg[1:0] == 2'b00 ? c8 : s32[bo +: 8]) :
                 rg[3:2] == 2'b10 ? r32[bo +: 8] : p32[bo +: 8];

   always_ff @(posedge clk) begin
      mem_rdata <= reset ? 8'h00 : rd_acc ? rsel : mem_rdata;
      mem_ready_out <= ~reset & rd_acc;
   end
endmodule

// File: tb/tb_mcs51_timer_array.sv
// tb_mcs51_timer_array: register vectors, timing corner sequences and randomized
// runs against an arithmetic tick-count model for the default NCH=2/WIDTH=16 build.
module tb_mcs51_timer_array;
   localparam int P = 12;

   typedef struct packed {
      logic        w;
      logic [15:0] a;
      logic [7:0]  d;
      logic [7:0]  e;
   } vec_t;

   logic clk = 1'b0, reset = 1'b1;
   logic mem_sel = 1'b0, mem_we_n = 1'b1, mem_rd_n = 1'b1, mem_sfr_n = 1'b1;
   logic [15:0] mem_addr = '0;
   logic [7:0] mem_wdata = '0;
   logic [1:0] cnt_in = '0, gate_in = '0;
   wire [7:0] mem_rdata;
   wire mem_ready_out;
   wire [1:0] irq;
   int cyc = 0, last = 0, n_chk = 0, n_fail = 0;
   vec_t tv[$];

   mcs51_timer_array dut (
      .clk(clk), .reset(reset), .mem_sel(mem_sel), .mem_we_n(mem_we_n), .mem_rd_n(mem_rd_n),
      .mem_sfr_n(mem_sfr_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready_out(mem_ready_out), .cnt_in(cnt_in), .gate_in(gate_in), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] adr(input int c, input int o);
      return 16'(32'hC0 + 16 * c + o);
   endfunction

   function automatic vec_t mk(input logic w, input logic [15:0] a, input logic [7:0] d, input logic [7:0] e);
      return '{w, a, d, e};
   endfunction

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      mem_sel = 1; mem_sfr_n = 0; mem_we_n = 0; mem_addr = a; mem_wdata = d;
      @(posedge clk); #1;
      last = cyc;
      mem_sel = 0; mem_sfr_n = 1; mem_we_n = 1;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] d);
      mem_sel = 1; mem_sfr_n = 0; mem_rd_n = 0; mem_addr = a;
      @(posedge clk); #1;
      mem_sel = 0; mem_sfr_n = 1; mem_rd_n = 1;
      d = mem_rdata;
      chk("ready", 32'(mem_ready_out), 32'd1);
   endtask

   task automatic rc(input string nm, input logic [15:0] a, input logic [7:0] e);
      logic [7:0] d;
      rd(a, d);
      chk(nm, 32'(d), 32'(e));
   endtask

   task automatic wr16(input int c, input int o, input logic [15:0] v);
      wr(adr(c, o), v[7:0]);
      wr(adr(c, o + 1), v[15:8]);
   endtask

   task automatic rc16(input string nm, input int c, input int o, input logic [15:0] e);
      rc(nm, adr(c, o), e[7:0]);
      rc(nm, adr(c, o + 1), e[15:8]);
   endtask

   task automatic wait_ticks(input int n);
      int k = 0;
      while (k < n) begin
         @(posedge clk); #1;
         if (cyc % P == 0) k++;
      end
   endtask

   task automatic align(input int r);
      do begin
         @(posedge clk); #1;
      end while (cyc % P != r);
   endtask

   initial begin
      tv.push_back(mk(0, 16'h00C0, 8'h00, 8'h00));
      tv.push_back(mk(0, 16'h00C1, 8'h00, 8'h00));
      tv.push_back(mk(0, 16'h00D0, 8'h00, 8'h00));
      tv.push_back(mk(0, 16'h00C4, 8'h00, 8'h00));
      tv.push_back(mk(0, 16'h00CC, 8'h00, 8'h00));
      tv.push_back(mk(1, 16'h00C0, 8'hFE, 8'h00));
      tv.push_back(mk(0, 16'h00C0, 8'h00, 8'h3E));
      tv.push_back(mk(0, 16'hABC0, 8'h00, 8'h3E));
      tv.push_back(mk(1, 16'h00C8, 8'hA5, 8'h00));
      tv.push_back(mk(1, 16'h00C9, 8'h5A, 8'h00));
      tv.push_back(mk(0, 16'h00C8, 8'h00, 8'hA5));
      tv.push_back(mk(0, 16'h00C9, 8'h00, 8'h5A));
      tv.push_back(mk(1, 16'h00CA, 8'h77, 8'h00));
      tv.push_back(mk(0, 16'h00CA, 8'h00, 8'h00));
      tv.push_back(mk(1, 16'h00C2, 8'h55, 8'h00));
      tv.push_back(mk(0, 16'h00C2, 8'h00, 8'h00));
      tv.push_back(mk(1, 16'h00D4, 8'h34, 8'h00));
      tv.push_back(mk(1, 16'h00D5, 8'h12, 8'h00));
      tv.push_back(mk(0, 16'h00D4, 8'h00, 8'h34));
      tv.push_back(mk(0, 16'h00D5, 8'h00, 8'h12));
      tv.push_back(mk(0, 16'h00D6, 8'h00, 8'h00));
      tv.push_back(mk(1, 16'h00E0, 8'hFF, 8'h00));
      tv.push_back(mk(0, 16'h00E0, 8'h00, 8'h00));
      tv.push_back(mk(1, 16'h00DC, 8'h99, 8'h00));
      tv.push_back(mk(0, 16'h00DC, 8'h00, 8'h00));
      tv.push_back(mk(1, 16'h00C0, 8'h00, 8'h00));
      tv.push_back(mk(1, 16'h00D4, 8'h00, 8'h00));
      tv.push_back(mk(1, 16'h00D5, 8'h00, 8'h00));
      tv.push_back(mk(1, 16'h00C8, 8'h00, 8'h00));
      tv.push_back(mk(1, 16'h00C9, 8'h00, 8'h00));

      repeat (3) @(posedge clk);
      #1 reset = 0;
      chk("reset rdata", 32'(mem_rdata), 0);
      chk("reset ready", 32'(mem_ready_out), 0);
      chk("reset irq", 32'(irq), 0);

      for (int i = 0; i < tv.size(); i++)
         if (tv[i].w) wr(tv[i].a, tv[i].d);
         else rc($sformatf("vec%0d", i), tv[i].a, tv[i].e);
      @(posedge clk); #1;
      chk("ready drops", 32'(mem_ready_out), 0);

      // free-run overflow, irq and W1C
      wr16(0, 4, 16'hFFFE);
      wr(adr(0, 0), 8'h21);
      wait_ticks(1);
      chk("fr irq early", 32'(irq[0]), 0);
      rc16("fr cnt1", 0, 4, 16'hFFFF);
      wait_ticks(1);
      chk("fr irq", 32'(irq[0]), 1);
      rc16("fr cnt2", 0, 4, 16'h0000);
      rc("fr stat", adr(0, 1), 8'h01);
      wr(adr(0, 1), 8'h01);
      chk("fr irq clr", 32'(irq[0]), 0);
      wr(adr(0, 0), 8'h00);

      // auto-reload period of 16 ticks
      wr16(1, 8, 16'hFFF0);
      wr16(1, 4, 16'hFFF0);
      wr(adr(1, 0), 8'h03);
      for (int r = 0; r < 2; r++) begin
         wait_ticks(15);
         rc("ar stat pre", adr(1, 1), 8'h00);
         wait_ticks(1);
         rc16("ar cnt", 1, 4, 16'hFFF0);
         rc("ar stat", adr(1, 1), 8'h01);
         chk("ar irq off", 32'(irq[1]), 0);
         wr(adr(1, 1), 8'h01);
      end
      wr(adr(1, 0), 8'h00);

      // one-shot stops itself
      wr16(0, 4, 16'hFFFF);
      wr(adr(0, 0), 8'h05);
      wait_ticks(1);
      rc16("os cnt", 0, 4, 16'h0000);
      rc("os stat", adr(0, 1), 8'h01);
      rc("os ctrl", adr(0, 0), 8'h04);
      repeat (1000) @(posedge clk);
      #1;
      rc16("os hold", 0, 4, 16'h0000);
      wr(adr(0, 1), 8'h01);
      wr(adr(0, 0), 8'h00);

      // coherent multi-byte read across a carry
      wr16(1, 4, 16'h00FF);
      align(P - 2);
      wr(adr(1, 0), 8'h01);
      rc("coh b0", adr(1, 4), 8'hFF);
      rc("coh b1", adr(1, 5), 8'h00);
      rc("coh b0 new", adr(1, 4), 8'h00);
      rc("coh b1 new", adr(1, 5), 8'h01);
      wr(adr(1, 0), 8'h00);

      // W1C colliding with overflow: hardware set wins
      wr16(0, 4, 16'hFFFF);
      wr(adr(0, 0), 8'h01);
      wait_ticks(1);
      wr16(0, 4, 16'hFFFF);
      align(P - 1);
      wr(adr(0, 1), 8'h01);
      rc("col tf", adr(0, 1), 8'h01);
      rc16("col cnt", 0, 4, 16'h0000);
      wr(adr(0, 1), 8'h01);
      rc("col tf clr", adr(0, 1), 8'h00);
      // CNT write colliding with an event: write wins, no overflow
      wr16(0, 4, 16'hFFFF);
      align(P - 1);
      wr(adr(0, 4), 8'hFF);
      wr(adr(0, 0), 8'h00);
      rc16("colw cnt", 0, 4, 16'hFFFF);
      rc("colw stat", adr(0, 1), 8'h00);

      // randomized runs: expected value from number of ticks seen while TR=1
      for (int it = 0; it < 20; it++) begin
         int c, m, d, a, e, ticks;
         logic [15:0] st, rl, v;
         logic tf, tr;
         c = int'($urandom_range(0, 1));
         m = int'($urandom_range(0, 2));
         d = int'($urandom_range(2, 300));
         st = 16'(32'hFFFF - $urandom_range(0, 30));
         rl = 16'(32'hFFFF - $urandom_range(0, 20));
         wr(adr(c, 0), 8'h00);
         wr(adr(c, 1), 8'h03);
         wr16(c, 8, rl);
         wr16(c, 4, st);
         wr(adr(c, 0), 8'(32'h21 | (m << 1)));
         a = last;
         repeat (d) @(posedge clk);
         #1;
         wr(adr(c, 0), 8'(32'h20 | (m << 1)));
         e = last;
         ticks = e / P - a / P;
         v = st; tf = 0; tr = 1;
         for (int k = 0; k < ticks && tr; k++)
            if (v == 16'hFFFF) begin
               tf = 1;
               v = (m == 1) ? rl : 16'h0000;
               if (m == 2) tr = 0;
            end else v = v + 16'd1;
         rc16($sformatf("rnd%0d cnt", it), c, 4, v);
         rc($sformatf("rnd%0d stat", it), adr(c, 1), {7'b0, tf});
         chk($sformatf("rnd%0d irq", it), 32'(irq[c]), 32'(tf));
         wr(adr(c, 0), 8'h00);
         wr(adr(c, 1), 8'h03);
      end

      // capture of an external count
      wr16(0, 4, 16'h0000);
      wr(adr(0, 0), 8'h0F);
      for (int k = 0; k < 16'h1234; k++) begin
         cnt_in[0] = 1'b1;
         @(posedge clk); #1;
         cnt_in[0] = 1'b0;
         @(posedge clk); #1;
      end
      repeat (5) @(posedge clk);
      #1 gate_in[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1 gate_in[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
`ifdef TIMER_CAPTURE_EN
      rc16("cap val", 0, 12, 16'h1234);
      rc("cap stat", adr(0, 1), 8'h02);
`else
      rc16("cap val", 0, 12, 16'h0000);
      rc("cap stat", adr(0, 1), 8'h00);
`endif
      rc16("cap cnt", 0, 4, 16'h1234);
      wr(adr(0, 0), 8'h00);

      // reset in the middle of activity
      wr16(0, 4, 16'hFFFF);
      wr(adr(0, 0), 8'h21);
      wait_ticks(1);
      chk("mid irq", 32'(irq[0]), 1);
      rc("mid ctrl", adr(0, 0), 8'h21);
      reset = 1;
      @(posedge clk);
      #1 reset = 0;
      chk("mid rst irq", 32'(irq), 0);
      chk("mid rst ready", 32'(mem_ready_out), 0);
      chk("mid rst rdata", 32'(mem_rdata), 0);
      rc("mid rst ctrl", adr(0, 0), 8'h00);
      rc("mid rst stat", adr(0, 1), 8'h00);
      rc16("mid rst cnt", 0, 4, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
